in3_debounce: RTL and testbench
===============================

# in3_debounce

Three-channel synchronizer and debouncer that sits directly upstream of the 3-input AND reduction stage. It takes three raw, asynchronous level inputs. It drives three clean, glitch-free levels (IN1, IN2, IN3) that the AND stage consumes unchanged. Each channel has its own two-flop synchronizer, a stability counter and a two-state FSM, so the downstream AND never sees metastable values or short glitches.

## Interface
- CNT_W, default 4: stability counter width in bits.
- STABLE_CYC, default 10: number of consecutive cycles a synchronized input must differ from its output before the output flips. Legal range is 1 .. 2^CNT_W-1.
- CLK  input  1  the single clock; all state updates on its rising edge.
- RST_N  input  1  reset, asynchronous and active-low; clears all state immediately on assertion.
- RAW1, RAW2, RAW3  input  1 each  raw asynchronous levels.
- IN1, IN2, IN3  output  1 each  debounced levels that feed the AND stage. Registered.
- CHG  output  3  per-channel one-cycle pulse in the cycle after the matching INx flips. Bit 2 is IN1, bit 1 is IN2, bit 0 is IN3. Registered.
- BUSY  output  1  high while any channel is in PEND. Combinational from the state registers only.

## Operation
- Synchronizer, per channel: s1 <= RAWx, then s2 <= s1. Only s2 is used downstream.
- FSM, per channel, with states STABLE and PEND:
  - STABLE, s2 == INx: stay; cnt = 0.
  - STABLE, s2 != INx: go to PEND; cnt <= 1.
  - PEND, s2 == INx (glitch ended early): go to STABLE; cnt <= 0; INx is unchanged and no CHG pulse is issued.
  - PEND, s2 != INx, cnt+1 < STABLE_CYC: stay; cnt <= cnt+1.
  - PEND, s2 != INx, cnt+1 == STABLE_CYC: INx <= ~INx; CHG bit <= 1; cnt <= 0; go to STABLE.
- STABLE_CYC == 1: the STABLE-state mismatch flips INx directly on the same edge, with no PEND visit.
- CHG bits are cleared on every edge where no flip occurs. Each flip produces exactly one high cycle.
- Channels are fully independent. Simultaneous flips on several channels set several CHG bits in the same cycle.
- The counter never wraps: it clears on flip or on revert. An out-of-range STABLE_CYC is illegal configuration.
- Reset values, asynchronous on RST_N low:
  - s1, s2 = 0
  - IN1..IN3 = 0
  - CHG = 3'b000
  - cnt = 0
  - state = STABLE
  - BUSY = 0
- Reset asserted mid-PEND: the pending flip is abandoned and INx returns to 0.
- After RST_N deasserts, a RAW held at 1 is re-qualified from scratch, with the full latency below.

## Timing
- Latency: RAWx changes before edge 0 and is held. s1 updates at edge 0 and s2 at edge 1. INx flips at edge STABLE_CYC+1, which is edge 11 with the defaults.
- CHG bit is high for exactly the one cycle following edge STABLE_CYC+1.
- Glitch rejection: any s2 excursion lasting STABLE_CYC-1 cycles or fewer never reaches INx.
- BUSY rises one edge after s2 first differs from INx. It falls on the flip edge or the revert edge.
- The downstream AND output follows the last of IN1..IN3 to rise, with no extra register in this block.

## Test plan
- Reset, then hold RAW1..RAW3 = 1 from edge 0: IN1..IN3 rise at edge 11, CHG = 3'b111 for one cycle, BUSY high during edges 2-10. The AND stage's OUT reads 1 from edge 11.
- Glitch: RAW2 pulses high for 8 cycles after settling at 0. IN2 stays 0, CHG[1] is never set, BUSY pulses then drops.
- Bounce: RAW1 toggles 1,0,1 with 3-cycle gaps, then holds 1. IN1 rises exactly 11 edges after the final toggle is captured, and exactly one CHG[2] pulse is issued.
- Staggered: RAW3 rises 4 cycles after RAW1/RAW2. CHG = 3'b110, then 3'b001 four cycles later. The AND output rises with IN3.
- Reset mid-operation: RST_N pulses low while RAW1 is pending at cnt = 6. All outputs read 0 immediately, without waiting for a clock edge. After release with RAW1 held 1, IN1 rises at edge 11 after release.
- Parameter corner with STABLE_CYC = 1, CNT_W = 1: a held change flips INx at edge 2, and BUSY stays 0 throughout.

Source files
------------

// File: rtl/in3_debounce.sv
// Three-channel two-flop synchronizer and debouncer feeding the 3-input AND stage.
// A channel output flips only after its synchronized input has disagreed with it for STABLE_CYC consecutive edges.
module in3_debounce #(
  parameter int CNT_W      = 4,
  parameter int STABLE_CYC = 10
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RAW1,
  input  logic       RAW2,
  input  logic       RAW3,
  output logic       IN1,
  output logic       IN2,
  output logic       IN3,
  output logic [2:0] CHG,
  output logic       BUSY
);

  // state    | meaning
  // ST_STABLE| synchronized input agrees with output, counter idle
  // ST_PEND  | input disagrees, counting consecutive mismatching cycles
  typedef enum logic {ST_STABLE = 1'b0, ST_PEND = 1'b1} state_t;

  localparam logic [CNT_W:0] LIMIT   = (CNT_W+1)'(STABLE_CYC);
  localparam bit             ONE_CYC = (STABLE_CYC == 1);

  // Channel index 2 is IN1, 1 is IN2, 0 is IN3, matching the CHG bit order.
  logic [2:0]       raw;
  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [2:0]       lvl;
  logic [2:0]       chg_q;
  logic [2:0]       nxt_lvl;
  logic [2:0]       nxt_chg;
  state_t           state     [3];
  state_t           nxt_state [3];
  logic [CNT_W-1:0] cnt       [3];
  logic [CNT_W-1:0] nxt_cnt   [3];

  assign raw = {RAW1, RAW2, RAW3};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lvl   <= '0;
      chg_q <= '0;
      for (int i = 0; i < 3; i++) begin
        state[i] <= ST_STABLE;
        cnt[i]   <= '0;
      end
    end else begin
      lvl   <= nxt_lvl;
      chg_q <= nxt_chg;
      for (int i = 0; i < 3; i++) begin
        state[i] <= nxt_state[i];
        cnt[i]   <= nxt_cnt[i];
      end
    end
  end

  always_comb begin
    nxt_lvl = lvl;
    nxt_chg = '0;
    for (int i = 0; i < 3; i++) begin
      nxt_state[i] = state[i];
      nxt_cnt[i]   = cnt[i];
      unique case (state[i])
        ST_STABLE: begin
          nxt_cnt[i] = '0;
          if (s2[i] != lvl[i]) begin
            if (ONE_CYC) begin
              nxt_lvl[i] = ~lvl[i];
              nxt_chg[i] = 1'b1;
            end else begin
              nxt_state[i] = ST_PEND;
              nxt_cnt[i]   = CNT_W'(1);
            end
          end
        end
        ST_PEND: begin
          if (s2[i] == lvl[i]) begin
            nxt_state[i] = ST_STABLE;
            nxt_cnt[i]   = '0;
          end else if (({1'b0, cnt[i]} + (CNT_W+1)'(1)) == LIMIT) begin
            nxt_state[i] = ST_STABLE;
            nxt_cnt[i]   = '0;
            nxt_lvl[i]   = ~lvl[i];
            nxt_chg[i]   = 1'b1;
          end else begin
            nxt_cnt[i] = cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          nxt_state[i] = ST_STABLE;
          nxt_cnt[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    BUSY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (state[i] == ST_PEND) BUSY = 1'b1;
    end
  end

  assign IN1 = lvl[2];
  assign IN2 = lvl[1];
  assign IN3 = lvl[0];
  assign CHG = chg_q;

endmodule

// File: tb/tb_in3_debounce.sv
// Bench for in3_debounce: default instance plus a STABLE_CYC=1 corner instance sharing the raw inputs,
// checked against a run-length reference model and directed timing expectations.
module tb_in3_debounce;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [2:0] raw = 3'b000;

  logic       a_in1, a_in2, a_in3, a_busy;
  logic [2:0] a_chg;
  logic       b_in1, b_in2, b_in3, b_busy;
  logic [2:0] b_chg;

  int checks = 0;
  int failures = 0;

  in3_debounce #(.CNT_W(4), .STABLE_CYC(10)) dut (
    .CLK(CLK), .RST_N(RST_N), .RAW1(raw[2]), .RAW2(raw[1]), .RAW3(raw[0]),
    .IN1(a_in1), .IN2(a_in2), .IN3(a_in3), .CHG(a_chg), .BUSY(a_busy)
  );

  in3_debounce #(.CNT_W(1), .STABLE_CYC(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .RAW1(raw[2]), .RAW2(raw[1]), .RAW3(raw[0]),
    .IN1(b_in1), .IN2(b_in2), .IN3(b_in3), .CHG(b_chg), .BUSY(b_busy)
  );

  always #5 CLK = ~CLK;

  // Reference: an output flips once its synchronized input has mismatched for N edges in a row.
  bit [2:0] m_s1, m_s2;
  bit [2:0] m_out [2];
  bit [2:0] m_chg [2];
  int       m_run [2][3];
  int       lim   [2] = '{10, 1};

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_s1 = '0;
      m_s2 = '0;
      for (int p = 0; p < 2; p++) begin
        m_out[p] = '0;
        m_chg[p] = '0;
        for (int i = 0; i < 3; i++) m_run[p][i] = 0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        m_chg[p] = '0;
        for (int i = 0; i < 3; i++) begin
          if (m_s2[i] != m_out[p][i]) begin
            m_run[p][i]++;
            if (m_run[p][i] == lim[p]) begin
              m_out[p][i] = ~m_out[p][i];
              m_chg[p][i] = 1'b1;
              m_run[p][i] = 0;
            end
          end else begin
            m_run[p][i] = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  end

  function automatic logic model_busy(int p);
    logic b = 1'b0;
    for (int i = 0; i < 3; i++) if (m_run[p][i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic expect_v(string tag, logic [2:0] obs, logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    expect_v("a_in",   {a_in1, a_in2, a_in3}, m_out[0]);
    expect_v("a_chg",  a_chg, m_chg[0]);
    expect_v("a_busy", {2'b00, a_busy}, {2'b00, model_busy(0)});
    expect_v("b_in",   {b_in1, b_in2, b_in3}, m_out[1]);
    expect_v("b_chg",  b_chg, m_chg[1]);
    expect_v("b_busy", {2'b00, b_busy}, {2'b00, model_busy(1)});
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
    check_all();
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  int saw_chg1;

  initial begin
    // Reset state
    #3;
    expect_v("rst_a_in", {a_in1, a_in2, a_in3}, 3'b000);
    expect_v("rst_a_chg", a_chg, 3'b000);
    expect_v("rst_busy", {1'b0, a_busy, b_busy}, 3'b000);
    @(posedge CLK);
    #2;
    check_all();

    // All three rise together: edge 0 is the first posedge after raw changes
    RST_N = 1'b1;
    raw   = 3'b111;
    for (int t = 1; t <= 13; t++) begin
      tick();
      expect_v("lat_a_in", {a_in1, a_in2, a_in3}, (t >= 12) ? 3'b111 : 3'b000);
      expect_v("lat_a_chg", a_chg, (t == 12) ? 3'b111 : 3'b000);
      expect_v("lat_a_busy", {2'b00, a_busy}, {2'b00, (t >= 3 && t <= 11)});
      expect_v("lat_b_in", {b_in1, b_in2, b_in3}, (t >= 3) ? 3'b111 : 3'b000);
      expect_v("lat_b_chg", b_chg, (t == 3) ? 3'b111 : 3'b000);
      expect_v("lat_b_busy", {2'b00, b_busy}, 3'b000);
      expect_v("lat_and", {2'b00, a_in1 & a_in2 & a_in3}, {2'b00, (t >= 12)});
    end

    // Glitch on RAW2 for 8 cycles after settling at 0
    raw = 3'b000;
    ticks(15);
    saw_chg1 = 0;
    raw[1] = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (a_chg[1]) saw_chg1++;
    end
    raw[1] = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (a_chg[1]) saw_chg1++;
    end
    expect_v("glitch_in2", {2'b00, a_in2}, 3'b000);
    expect_v("glitch_chg1_count", 3'(saw_chg1), 3'd0);
    expect_v("glitch_busy", {2'b00, a_busy}, 3'b000);

    // Bounce on RAW1, then hold high
    raw[2] = 1'b1; ticks(3);
    raw[2] = 1'b0; ticks(3);
    raw[2] = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      tick();
      expect_v("bounce_in1", {2'b00, a_in1}, {2'b00, (t >= 12)});
      expect_v("bounce_chg2", {2'b00, a_chg[2]}, {2'b00, (t == 12)});
    end

    // Staggered: RAW3 four cycles after RAW1/RAW2
    raw = 3'b000;
    ticks(15);
    raw = 3'b110;
    ticks(4);
    raw = 3'b111;
    for (int t = 5; t <= 18; t++) begin
      tick();
      expect_v("stag_chg", a_chg, (t == 12) ? 3'b110 : (t == 16) ? 3'b001 : 3'b000);
      expect_v("stag_and", {2'b00, a_in1 & a_in2 & a_in3}, {2'b00, (t >= 16)});
    end

    // Reset while RAW1 is pending at cnt = 6 and IN2/IN3 are high
    raw = 3'b011;
    ticks(15);
    raw = 3'b111;
    ticks(8);
    expect_v("pre_rst_busy", {2'b00, a_busy}, 3'b001);
    #1 RST_N = 1'b0;
    #1;
    expect_v("async_a_in", {a_in1, a_in2, a_in3}, 3'b000);
    expect_v("async_b_in", {b_in1, b_in2, b_in3}, 3'b000);
    expect_v("async_chg_busy", {a_chg[0] | b_chg[0], a_busy, b_busy}, 3'b000);
    check_all();
    @(posedge CLK);
    #2;
    check_all();
    RST_N = 1'b1;
    for (int t = 1; t <= 13; t++) begin
      tick();
      expect_v("rel_a_in", {a_in1, a_in2, a_in3}, (t >= 12) ? 3'b111 : 3'b000);
    end

    // Random stimulus with occasional single-bit toggles
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(5) == 0) begin
        int idx;
        idx = int'($urandom_range(2));
        raw[idx] = ~raw[idx];
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
